// File: rtl/serial_mag_compare_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_t : controller states (IDLE, RUN, DONE)
//   EQ_INIT : cascade "equal so far" value loaded at the start of a compare
//   GT_INIT : cascade "greater so far" value loaded at the start of a compare
package serial_mag_compare_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic EQ_INIT = 1'b1;
  localparam logic GT_INIT = 1'b0;

endpackage

// File: rtl/serial_mag_compare_twobit.sv
// Combinational two-bit cascade comparator slice.
//   eq_in, gt_in : cascade state from the more significant digits
//   a, b         : current 2-bit digit pair
//   eq_out       : all digits so far are equal
//   gt_out       : A is greater considering all digits so far
module twobit (
  input  logic       eq_in,
  input  logic       gt_in,
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq_out,
  output logic       gt_out
);

  // Once a more significant digit has decided the result, the lower
  // digits are ignored and the decision is passed through.
  assign eq_out = eq_in & ~gt_in & (a == b);
  assign gt_out = (eq_in & ~gt_in & (a > b)) | (~eq_in & gt_in);

endmodule

// File: rtl/serial_mag_compare.sv
// Multi-cycle unsigned magnitude comparator, one 2-bit digit per clock,
// most significant digit first, through a single shared cascade slice.
//   clk   : clock, all updates on the rising edge
//   rst   : synchronous active-high reset
//   start : request a compare, accepted only when idle
//   a, b  : operands, captured on an accepted start
//   busy  : high while a compare is running or completing
//   done  : one-cycle pulse, result flags valid
//   eq/gt/lt : registered result, held until the next accepted start
module serial_mag_compare
  import serial_mag_compare_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int N     = WIDTH / 2;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IDX_W-1:0] idx;
  logic             eq_c, gt_c;
  logic [1:0]       a_dig, b_dig;
  logic             eq_nxt, gt_nxt;
  logic             last_digit;

  // Digit mux: select the pair addressed by idx.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) begin
        a_dig = a_reg[2*i +: 2];
        b_dig = b_reg[2*i +: 2];
      end
    end
  end

  twobit u_slice (
    .eq_in  (eq_c),
    .gt_in  (gt_c),
    .a      (a_dig),
    .b      (b_dig),
    .eq_out (eq_nxt),
    .gt_out (gt_nxt)
  );

  assign last_digit = (idx == '0) || ((EARLY_EXIT != 0) && !eq_nxt);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)      state_nxt = ST_RUN;
      ST_RUN:  if (last_digit) state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      idx   <= '0;
      eq_c  <= '0;
      gt_c  <= '0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= IDX_W'(N - 1);
            eq_c  <= EQ_INIT;
            gt_c  <= GT_INIT;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
          end
        end
        ST_RUN: begin
          eq_c <= eq_nxt;
          gt_c <= gt_nxt;
          if (idx != '0) idx <= idx - IDX_W'(1);
          if (last_digit) begin
            eq <= eq_nxt;
            gt <= gt_nxt;
            lt <= ~eq_nxt & ~gt_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_mag_compare.sv
// Bench for serial_mag_compare: two instances (EARLY_EXIT=0 and 1) checked
// every cycle against a timing/result model built from plain arithmetic,
// plus directed cases with hand-computed latency and flags.
module tb_serial_mag_compare;

  localparam int W = 8;
  localparam int N = W / 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_v [2];
  logic [W-1:0] a_v     [2];
  logic [W-1:0] b_v     [2];
  logic         busy_v  [2];
  logic         done_v  [2];
  logic         eq_v    [2];
  logic         gt_v    [2];
  logic         lt_v    [2];

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_mag_compare #(.WIDTH(W), .EARLY_EXIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .eq(eq_v[0]), .gt(gt_v[0]), .lt(lt_v[0])
  );

  serial_mag_compare #(.WIDTH(W), .EARLY_EXIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .eq(eq_v[1]), .gt(gt_v[1]), .lt(lt_v[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycles spent in RUN: always N, or up to the first unequal digit with early exit.
  function automatic int lat_of(input int ee, input logic [W-1:0] a, input logic [W-1:0] b);
    if (ee == 0) return N;
    for (int j = 0; j < N; j++)
      if (((a >> (W - 2 - 2*j)) & 8'h3) != ((b >> (W - 2 - 2*j)) & 8'h3)) return j + 1;
    return N;
  endfunction

  // Model: m_cnt = remaining busy cycles (RUN cycles + one DONE cycle).
  int   m_cnt [2] = '{0, 0};
  logic m_eq  [2] = '{1'b0, 1'b0};
  logic m_gt  [2] = '{1'b0, 1'b0};
  logic m_lt  [2] = '{1'b0, 1'b0};
  logic p_eq  [2] = '{1'b0, 1'b0};
  logic p_gt  [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_cnt[d] <= 0;
        m_eq[d] <= 1'b0; m_gt[d] <= 1'b0; m_lt[d] <= 1'b0;
      end else if (m_cnt[d] == 0) begin
        if (start_v[d]) begin
          m_cnt[d] <= lat_of(d, a_v[d], b_v[d]) + 1;
          p_eq[d]  <= (a_v[d] == b_v[d]);
          p_gt[d]  <= (a_v[d] > b_v[d]);
          m_eq[d] <= 1'b0; m_gt[d] <= 1'b0; m_lt[d] <= 1'b0;
        end
      end else begin
        m_cnt[d] <= m_cnt[d] - 1;
        if (m_cnt[d] == 2) begin
          m_eq[d] <= p_eq[d];
          m_gt[d] <= p_gt[d];
          m_lt[d] <= !p_eq[d] && !p_gt[d];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model_busy%0d", d), 32'(busy_v[d]), 32'(m_cnt[d] != 0));
        chk($sformatf("model_done%0d", d), 32'(done_v[d]), 32'(m_cnt[d] == 1));
        chk($sformatf("model_flags%0d", d), {29'd0, eq_v[d], gt_v[d], lt_v[d]},
            {29'd0, m_eq[d], m_gt[d], m_lt[d]});
      end
    end
  end

  // Launch one compare from idle and check its latency and flags against literals.
  task automatic do_cmp(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [2:0] exp_flags, input string name);
    int cyc;
    start_v[d] = 1'b1; a_v[d] = a; b_v[d] = b;
    @(negedge clk);
    start_v[d] = 1'b0; a_v[d] = W'($urandom); b_v[d] = W'($urandom);
    cyc = 0;
    while (!done_v[d] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({name, "_flags"}, {29'd0, eq_v[d], gt_v[d], lt_v[d]}, {29'd0, exp_flags});
    @(negedge clk);
    chk({name, "_idle"}, 32'(busy_v[d]), 32'd0);
  endtask

  task automatic rand_run(input int d, input int cycles);
    logic [W-1:0] x;
    for (int i = 0; i < cycles; i++) begin
      x = W'($urandom);
      a_v[d] = x;
      case ($urandom_range(0, 3))
        0:       b_v[d] = x;
        1:       b_v[d] = x ^ W'(1 << $urandom_range(0, W - 1));
        default: b_v[d] = W'($urandom);
      endcase
      start_v[d] = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    start_v[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; a_v[d] = '0; b_v[d] = '0;
    end
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_outs%0d", d),
          {27'd0, busy_v[d], done_v[d], eq_v[d], gt_v[d], lt_v[d]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_cmp(0, 8'hA5, 8'hA5, 4, 3'b100, "eq_a5");
    do_cmp(0, 8'h80, 8'h7F, 4, 3'b010, "gt_80_7f");
    do_cmp(0, 8'hFE, 8'hFF, 4, 3'b001, "lt_fe_ff");
    do_cmp(1, 8'h40, 8'h80, 1, 3'b001, "ee_lt_40_80");
    do_cmp(1, 8'h33, 8'h33, 4, 3'b100, "ee_eq_33");
    do_cmp(1, 8'h37, 8'h34, 4, 3'b010, "ee_gt_lsb");

    // Starts during RUN and DONE are ignored.
    start_v[0] = 1'b1; a_v[0] = 8'h12; b_v[0] = 8'h34;   // accepted at edge k
    @(negedge clk); start_v[0] = 1'b0;
    @(negedge clk); start_v[0] = 1'b1; a_v[0] = 8'hFF; b_v[0] = 8'h00; // edge k+2
    @(negedge clk); start_v[0] = 1'b0;
    @(negedge clk); start_v[0] = 1'b1; a_v[0] = 8'h99; b_v[0] = 8'h99; // edge k+4
    @(negedge clk);
    chk("ignore_done", 32'(done_v[0]), 32'd1);
    chk("ignore_flags", {29'd0, eq_v[0], gt_v[0], lt_v[0]}, 32'b001);
    a_v[0] = 8'hEE; b_v[0] = 8'h11;                       // edge k+5 in DONE
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("ignore_single_done", 32'(done_v[0]), 32'd0);
    chk("ignore_idle", 32'(busy_v[0]), 32'd0);
    do_cmp(0, 8'h55, 8'h54, 4, 3'b010, "after_ignore");

    // Reset mid-RUN discards the compare.
    start_v[1] = 1'b1; a_v[1] = 8'h3C; b_v[1] = 8'h3C;
    @(negedge clk); start_v[1] = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_run", {28'd0, busy_v[1], eq_v[1], gt_v[1], lt_v[1]}, 32'd0);
    @(negedge clk);
    chk("rst_no_done", 32'(done_v[1]), 32'd0);
    do_cmp(1, 8'h00, 8'hFF, 1, 3'b001, "post_rst_lt");

    // Back-to-back with start held high: one acceptance every N+2 cycles.
    start_v[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_v[0] = W'($urandom); b_v[0] = (i % 3 == 0) ? a_v[0] : W'($urandom);
      @(negedge clk);
      chk("b2b_accept", 32'(busy_v[0]), 32'd1);
      a_v[0] = W'($urandom); b_v[0] = W'($urandom);
      repeat (N + 1) @(negedge clk);
    end
    start_v[0] = 1'b0;
    repeat (N + 2) @(negedge clk);

    fork
      rand_run(0, 1500);
      rand_run(1, 1500);
    join
    repeat (N + 3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
